// File: rtl/complete_arbiter_pkg.sv
// ============================================================================
// Module : complete_arbiter_pkg
// Brief  : Shared types, widths and wrapping seq-num age compare for the
//          completion arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package complete_arbiter_pkg;

    localparam int C_DEF_SEQ_NUM_BITS  = 5;
    localparam int C_DEF_NUM_PHYS_REGS = 36;
    localparam int C_ARCH_REG_BITS     = 5;
    localparam int C_DATA_BITS         = 32;

    function automatic int preg_width(input int num_phys_regs);
        return (num_phys_regs > 1) ? $clog2(num_phys_regs) : 1;
    endfunction

    localparam int C_DEF_PW = preg_width(C_DEF_NUM_PHYS_REGS);

    typedef struct packed {
        logic [C_DEF_SEQ_NUM_BITS-1:0] seq_num;
        logic [C_ARCH_REG_BITS-1:0]    waddr;
        logic [C_DEF_PW-1:0]           preg;
        logic [C_DATA_BITS-1:0]        wdata;
        logic                          wen;
    } completion_t;

    // True when a is strictly older than b in a wrapping space of 'bits' bits
    // (bits < 32): b is 1 .. 2^(bits-1)-1 steps ahead of a.
    function automatic logic seq_is_older(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int          bits);
        logic [31:0] mask;
        logic [31:0] half;
        logic [31:0] diff;
        mask = (32'd1 << bits) - 32'd1;
        half = 32'd1 << (bits - 1);
        diff = (b - a) & mask;
        return (diff != 32'd0) && (diff < half);
    endfunction

endpackage

`default_nettype wire

// File: rtl/complete_arbiter_rr_arbiter.sv
// ============================================================================
// Module : complete_arbiter_rr_arbiter
// Brief  : Round-robin one-hot arbiter; owns the rotating priority pointer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module complete_arbiter_rr_arbiter #(
    parameter int P_NUM_REQS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic [P_NUM_REQS-1:0] i_eligible,
    output logic [P_NUM_REQS-1:0] o_grant
);

    localparam int C_PTR_W = (P_NUM_REQS > 1) ? $clog2(P_NUM_REQS) : 1;

    logic [C_PTR_W-1:0]    r_ptr_q;
    logic [C_PTR_W-1:0]    w_ptr_d;
    logic [P_NUM_REQS-1:0] w_grant;
    logic                  w_found;
    int                    w_idx;
    int                    w_nxt;

    // Scan from the pointer upward, wrapping; the first eligible requester wins.
    always_comb begin
        w_grant = '0;
        w_ptr_d = r_ptr_q;
        w_found = 1'b0;
        w_idx   = 0;
        w_nxt   = 0;
        if (i_en) begin
            for (int k = 0; k < P_NUM_REQS; k++) begin
                w_idx = int'(r_ptr_q) + k;
                if (w_idx >= P_NUM_REQS) begin
                    w_idx = w_idx - P_NUM_REQS;
                end
                if (!w_found && i_eligible[w_idx[C_PTR_W-1:0]]) begin
                    w_found                      = 1'b1;
                    w_grant[w_idx[C_PTR_W-1:0]] = 1'b1;
                    w_nxt                        = (w_idx == P_NUM_REQS - 1) ? 0 : w_idx + 1;
                    w_ptr_d                      = w_nxt[C_PTR_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr_q <= '0;
        end else begin
            r_ptr_q <= w_ptr_d;
        end
    end

    assign o_grant = w_grant;

endmodule

`default_nettype wire

// File: rtl/complete_arbiter.sv
// ============================================================================
// Module : complete_arbiter
// Brief  : Round-robin arbitration of execute-pipe completions onto the single
//          registered CompleteNotif bus, filtering squashed requests.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module complete_arbiter
    import complete_arbiter_pkg::*;
#(
    parameter int P_NUM_PIPES     = 3,
    parameter int P_SEQ_NUM_BITS  = C_DEF_SEQ_NUM_BITS,
    parameter int P_NUM_PHYS_REGS = C_DEF_NUM_PHYS_REGS,
    localparam int C_PW           = preg_width(P_NUM_PHYS_REGS)
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [P_NUM_PIPES-1:0]                        req_val,
    output logic [P_NUM_PIPES-1:0]                        req_rdy,
    input  logic [P_NUM_PIPES-1:0][P_SEQ_NUM_BITS-1:0]    req_seq_num,
    input  logic [P_NUM_PIPES-1:0][C_ARCH_REG_BITS-1:0]   req_waddr,
    input  logic [P_NUM_PIPES-1:0][C_PW-1:0]              req_preg,
    input  logic [P_NUM_PIPES-1:0][C_DATA_BITS-1:0]       req_wdata,
    input  logic [P_NUM_PIPES-1:0]                        req_wen,
    input  logic                                          squash_val,
    input  logic [P_SEQ_NUM_BITS-1:0]                     squash_seq_num,
    output logic                                          complete_val,
    output logic [P_SEQ_NUM_BITS-1:0]                     complete_seq_num,
    output logic [C_ARCH_REG_BITS-1:0]                    complete_waddr,
    output logic [C_PW-1:0]                               complete_preg,
    output logic [C_DATA_BITS-1:0]                        complete_wdata,
    output logic                                          complete_wen
);

    logic [P_NUM_PIPES-1:0]     w_eligible;
    logic [P_NUM_PIPES-1:0]     w_grant;
    logic                       w_complete_val_d;
    logic [P_SEQ_NUM_BITS-1:0]  w_complete_seq_d;
    logic [C_ARCH_REG_BITS-1:0] w_complete_waddr_d;
    logic [C_PW-1:0]            w_complete_preg_d;
    logic [C_DATA_BITS-1:0]     w_complete_wdata_d;
    logic                       w_complete_wen_d;
    logic                       r_complete_val_q;
    logic [P_SEQ_NUM_BITS-1:0]  r_complete_seq_q;
    logic [C_ARCH_REG_BITS-1:0] r_complete_waddr_q;
    logic [C_PW-1:0]            r_complete_preg_q;
    logic [C_DATA_BITS-1:0]     r_complete_wdata_q;
    logic                       r_complete_wen_q;

    // A request is killed only if the squasher is strictly older; equal survives.
    for (genvar gi = 0; gi < P_NUM_PIPES; gi++) begin : g_elig
        assign w_eligible[gi] = req_val[gi] &
            ~(squash_val & seq_is_older(32'(squash_seq_num), 32'(req_seq_num[gi]),
                                        P_SEQ_NUM_BITS));
    end

    complete_arbiter_rr_arbiter #(
        .P_NUM_REQS (P_NUM_PIPES)
    ) u_rr_arbiter (
        .clk        (clk),
        .rst        (rst),
        .i_en       (~rst),
        .i_eligible (w_eligible),
        .o_grant    (w_grant)
    );

    assign req_rdy = w_grant;

    always_comb begin
        w_complete_val_d   = |w_grant;
        w_complete_seq_d   = '0;
        w_complete_waddr_d = '0;
        w_complete_preg_d  = '0;
        w_complete_wdata_d = '0;
        w_complete_wen_d   = 1'b0;
        for (int i = 0; i < P_NUM_PIPES; i++) begin
            if (w_grant[i]) begin
                w_complete_seq_d   = req_seq_num[i];
                w_complete_waddr_d = req_waddr[i];
                w_complete_preg_d  = req_preg[i];
                w_complete_wdata_d = req_wdata[i];
                w_complete_wen_d   = req_wen[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_complete_val_q <= 1'b0;
        end else begin
            r_complete_val_q <= w_complete_val_d;
        end
    end

    // Payload is don't-care while the valid bit is low, so it carries no reset.
    always_ff @(posedge clk) begin
        r_complete_seq_q   <= w_complete_seq_d;
        r_complete_waddr_q <= w_complete_waddr_d;
        r_complete_preg_q  <= w_complete_preg_d;
        r_complete_wdata_q <= w_complete_wdata_d;
        r_complete_wen_q   <= w_complete_wen_d;
    end

    assign complete_val     = r_complete_val_q;
    assign complete_seq_num = r_complete_seq_q;
    assign complete_waddr   = r_complete_waddr_q;
    assign complete_preg    = r_complete_preg_q;
    assign complete_wdata   = r_complete_wdata_q;
    assign complete_wen     = r_complete_wen_q;

`ifndef SYNTHESIS
    // A live request left waiting must hold its payload until granted or dropped.
    for (genvar gi = 0; gi < P_NUM_PIPES; gi++) begin : g_stable_chk
        a_req_stable : assert property (@(posedge clk) disable iff (rst)
            ($past(w_eligible[gi] & ~req_rdy[gi]) && req_val[gi]) |->
            ($stable(req_seq_num[gi]) && $stable(req_waddr[gi]) &&
             $stable(req_preg[gi]) && $stable(req_wdata[gi]) && $stable(req_wen[gi])));
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_complete_arbiter.sv
// ============================================================================
// Module : tb_complete_arbiter
// Brief  : Directed self-checking bench for complete_arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_complete_arbiter;

    logic             clk;
    logic             rst;
    logic [2:0]       req_val;
    logic [2:0]       req_rdy;
    logic [2:0][4:0]  req_seq_num;
    logic [2:0][4:0]  req_waddr;
    logic [2:0][5:0]  req_preg;
    logic [2:0][31:0] req_wdata;
    logic [2:0]       req_wen;
    logic             squash_val;
    logic [4:0]       squash_seq_num;
    logic             complete_val;
    logic [4:0]       complete_seq_num;
    logic [4:0]       complete_waddr;
    logic [5:0]       complete_preg;
    logic [31:0]      complete_wdata;
    logic             complete_wen;

    int n_pass;
    int n_total;

    complete_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .req_val          (req_val),
        .req_rdy          (req_rdy),
        .req_seq_num      (req_seq_num),
        .req_waddr        (req_waddr),
        .req_preg         (req_preg),
        .req_wdata        (req_wdata),
        .req_wen          (req_wen),
        .squash_val       (squash_val),
        .squash_seq_num   (squash_seq_num),
        .complete_val     (complete_val),
        .complete_seq_num (complete_seq_num),
        .complete_waddr   (complete_waddr),
        .complete_preg    (complete_preg),
        .complete_wdata   (complete_wdata),
        .complete_wen     (complete_wen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Inputs change 1 time unit after the edge; checks happen mid-cycle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic set_pipe(input int p, input logic [4:0] seq, input logic [4:0] waddr,
                            input logic [5:0] preg, input logic [31:0] wdata,
                            input logic wen);
        req_seq_num[p] = seq;
        req_waddr[p]   = waddr;
        req_preg[p]    = preg;
        req_wdata[p]   = wdata;
        req_wen[p]     = wen;
    endtask

    initial begin
        n_pass         = 0;
        n_total        = 0;
        rst            = 1'b1;
        req_val        = '0;
        req_seq_num    = '0;
        req_waddr      = '0;
        req_preg       = '0;
        req_wdata      = '0;
        req_wen        = '0;
        squash_val     = 1'b0;
        squash_seq_num = '0;

        // Reset holds rdy low even with all pipes requesting
        next_cycle();
        for (int p = 0; p < 3; p++) set_pipe(p, 5'(10 + p), 5'(p + 1), 6'(p), 32'(p), 1'b1);
        req_val = 3'b111;
        settle();
        chk("reset_rdy", 32'(req_rdy), 32'h0);
        chk("reset_cval", 32'(complete_val), 32'h0);

        // Contention from reset: grants 0,1,2,0,1
        next_cycle(); rst = 1'b0; settle();
        chk("cont_rdy_c1", 32'(req_rdy), 32'b001);
        chk("cont_cval_c1", 32'(complete_val), 32'h0);
        next_cycle(); settle();
        chk("cont_rdy_c2", 32'(req_rdy), 32'b010);
        chk("cont_seq_c2", 32'(complete_seq_num), 32'd10);
        next_cycle(); settle();
        chk("cont_rdy_c3", 32'(req_rdy), 32'b100);
        chk("cont_seq_c3", 32'(complete_seq_num), 32'd11);
        next_cycle(); settle();
        chk("cont_rdy_c4", 32'(req_rdy), 32'b001);
        chk("cont_seq_c4", 32'(complete_seq_num), 32'd12);
        next_cycle(); settle();
        chk("cont_rdy_c5", 32'(req_rdy), 32'b010);
        chk("cont_seq_c5", 32'(complete_seq_num), 32'd10);

        // Reset mid-operation with ptr=2 and a valid registered entry
        next_cycle(); rst = 1'b1; settle();
        chk("midrst_rdy", 32'(req_rdy), 32'h0);
        chk("midrst_cval", 32'(complete_val), 32'h1);
        chk("midrst_seq", 32'(complete_seq_num), 32'd11);
        next_cycle(); rst = 1'b0; settle();
        chk("postrst_cval", 32'(complete_val), 32'h0);
        chk("postrst_rdy", 32'(req_rdy), 32'b001);
        next_cycle(); req_val = 3'b000; settle();
        chk("postrst_seq", 32'(complete_seq_num), 32'd10);
        chk("idle_rdy", 32'(req_rdy), 32'h0);
        next_cycle(); settle();
        chk("idle_cval", 32'(complete_val), 32'h0);

        // Fairness after skip: ptr=1, pipes 0 and 2 request
        next_cycle(); req_val = 3'b101; settle();
        chk("fair_rdy_a", 32'(req_rdy), 32'b100);
        next_cycle(); settle();
        chk("fair_rdy_b", 32'(req_rdy), 32'b001);
        chk("fair_seq_b", 32'(complete_seq_num), 32'd12);
        next_cycle(); req_val = 3'b000; settle();
        chk("fair_seq_c", 32'(complete_seq_num), 32'd10);

        // Single request on pipe 1
        next_cycle();
        set_pipe(1, 5'd3, 5'd7, 6'd12, 32'hDEADBEEF, 1'b1);
        req_val = 3'b010;
        settle();
        chk("single_rdy", 32'(req_rdy), 32'b010);
        next_cycle(); req_val = 3'b000; settle();
        chk("single_cval", 32'(complete_val), 32'h1);
        chk("single_seq", 32'(complete_seq_num), 32'd3);
        chk("single_waddr", 32'(complete_waddr), 32'd7);
        chk("single_preg", 32'(complete_preg), 32'd12);
        chk("single_wdata", complete_wdata, 32'hDEADBEEF);
        chk("single_wen", 32'(complete_wen), 32'h1);
        next_cycle(); settle();
        chk("single_after", 32'(complete_val), 32'h0);

        // Squash filter: squash 4, pipe0 seq 5 (killed), pipe1 seq 2 (older)
        next_cycle();
        squash_val     = 1'b1;
        squash_seq_num = 5'd4;
        set_pipe(0, 5'd5, 5'd1, 6'd20, 32'h55, 1'b1);
        set_pipe(1, 5'd2, 5'd2, 6'd21, 32'h22, 1'b1);
        req_val = 3'b011;
        settle();
        chk("sq_rdy_a", 32'(req_rdy), 32'b010);
        next_cycle();
        set_pipe(0, 5'd4, 5'd1, 6'd20, 32'h44, 1'b1);
        req_val = 3'b001;
        settle();
        chk("sq_equal_rdy", 32'(req_rdy), 32'b001);
        chk("sq_seq_a", 32'(complete_seq_num), 32'd2);

        // Wrap-around age: squash 30 kills seq 1, spares seq 29
        next_cycle();
        squash_seq_num = 5'd30;
        set_pipe(0, 5'd1, 5'd1, 6'd20, 32'h11, 1'b1);
        settle();
        chk("wrap_young_rdy", 32'(req_rdy), 32'h0);
        chk("sq_reg_entry_cval", 32'(complete_val), 32'h1);
        chk("sq_reg_entry_seq", 32'(complete_seq_num), 32'd4);
        next_cycle();
        set_pipe(0, 5'd29, 5'd9, 6'd33, 32'h1234, 1'b0);
        settle();
        chk("wrap_old_rdy", 32'(req_rdy), 32'b001);
        chk("wrap_filtered_cval", 32'(complete_val), 32'h0);
        next_cycle(); req_val = 3'b000; squash_val = 1'b0; settle();
        chk("wrap_cval", 32'(complete_val), 32'h1);
        chk("wrap_seq", 32'(complete_seq_num), 32'd29);
        chk("nowen_wen", 32'(complete_wen), 32'h0);
        chk("nowen_preg", 32'(complete_preg), 32'd33);
        next_cycle(); settle();
        chk("final_idle", 32'(complete_val), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
